// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   main_state_t  - main controller states (run / drain / halted)
//   mw_state_t    - memory-wait sub-FSM states
//   REG_ZERO      - architectural zero register, never a real hazard source
//   pipe_ctrl_t   - bundle of the pipeline control outputs, plus the fixed
//                   output patterns the controller selects between
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      MS_RUN    = 2'd0,
      MS_DRAIN  = 2'd1,
      MS_HALTED = 2'd2
   } main_state_t;

   typedef enum logic {
      MW_IDLE = 1'b0,
      MW_WAIT = 1'b1
   } mw_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic ifid_flush;
      logic idex_we;
      logic idex_flush;
      logic freeze;
   } pipe_ctrl_t;

   // Free-running pipeline: everything advances, nothing is squashed.
   localparam pipe_ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                          idex_we: 1'b1, idex_flush: 1'b0, freeze: 1'b0};
   // Memory wait: the whole pipeline holds, including EX/MEM and MEM/WB.
   localparam pipe_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                          idex_we: 1'b0, idex_flush: 1'b0, freeze: 1'b1};
   // Taken branch in EX: PC loads the target, both younger stages are squashed.
   localparam pipe_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                          idex_we: 1'b1, idex_flush: 1'b1, freeze: 1'b0};
   // HALT leaving ID: HALT itself moves into ID/EX, fetch stops.
   localparam pipe_ctrl_t CTRL_HALT   = '{pc_we: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1,
                                          idex_we: 1'b1, idex_flush: 1'b0, freeze: 1'b0};
   // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
   localparam pipe_ctrl_t CTRL_STALL  = '{pc_we: 1'b0, ifid_we: 1'b1 ^ 1'b1, ifid_flush: 1'b0,
                                          idex_we: 1'b1, idex_flush: 1'b1, freeze: 1'b0};
   // Drain / halted: only bubbles enter the pipe while older work retires.
   localparam pipe_ctrl_t CTRL_DRAIN  = '{pc_we: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1,
                                          idex_we: 1'b1, idex_flush: 1'b1, freeze: 1'b0};

endpackage

// File: rtl/mem_wait_ctrl.sv
// ---------------------------------------------------------------------------
// mem_wait_ctrl
// Memory-wait sub-FSM. Stretches each data-memory access in MEM to MEM_LAT
// cycles by freezing the pipeline for MEM_LAT-1 cycles.
// Ports:
//   clk        in   system clock
//   srst       in   synchronous active-high reset
//   mem_access in   instruction in MEM is a load or store
//   freeze     out  hold the pipeline this cycle (registered state + input)
// ---------------------------------------------------------------------------
module mem_wait_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic srst,
   input  logic mem_access,
   output logic freeze
);
   import pipe_ctrl_pkg::*;

   localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_LAT > 2) ? MEM_LAT - 2 : 0);
   localparam logic HAS_WAIT = (MEM_LAT > 1);

   mw_state_t         mw_state_reg;
   mw_state_t         mw_state_next;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [WAIT_W-1:0] wait_cnt_next;

   // State register
   always_ff @(posedge clk) begin
      if (srst) begin
         mw_state_reg <= MW_IDLE;
         wait_cnt_reg <= '0;
      end else begin
         mw_state_reg <= mw_state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Next-state logic. The cycle leaving MW_WAIT still sees the same
   // instruction in MEM, so mem_access is not looked at there.
   always_comb begin
      mw_state_next = mw_state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (mw_state_reg)
         MW_IDLE: begin
            if (HAS_WAIT && mem_access) begin
               mw_state_next = MW_WAIT;
               wait_cnt_next = WAIT_LOAD;
            end
         end
         MW_WAIT: begin
            if (wait_cnt_reg != '0) begin
               wait_cnt_next = wait_cnt_reg - 1'b1;
            end else begin
               mw_state_next = MW_IDLE;
            end
         end
         default: mw_state_next = MW_IDLE;
      endcase
   end

   // Output logic: the first freeze cycle happens in MW_IDLE itself.
   always_comb begin
      freeze = 1'b0;
      case (mw_state_reg)
         MW_IDLE: freeze = HAS_WAIT && mem_access;
         MW_WAIT: freeze = (wait_cnt_reg != '0);
         default: freeze = 1'b0;
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall / flush / freeze controller for the 5-stage pipeline.
// Inputs : CLOCK, RESET (sync, active high); ID stage operand/halt info;
//          EX stage load/destination/branch info; MEM_Access.
// Outputs: PC_WriteEN, IFID_WriteEN/Flush, IDEX_WriteEN/Flush, Pipe_Freeze
//          (combinational from state + inputs); Halted, StallCount and
//          FlushCount (registered, saturating counters).
// Priority when not in reset: freeze > branch flush > halt > load-use stall.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int MEM_LAT      = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             ID_Valid,
   input  logic [4:0]       ID_RSAddr,
   input  logic [4:0]       ID_RTAddr,
   input  logic             ID_UsesRS,
   input  logic             ID_UsesRT,
   input  logic             ID_Halt,
   input  logic             EX_RegWriteEN,
   input  logic             EX_Mem2RegSEL,
   input  logic [4:0]       EX_DstAddr,
   input  logic             EX_BranchTaken,
   input  logic             MEM_Access,
   output logic             PC_WriteEN,
   output logic             IFID_WriteEN,
   output logic             IFID_Flush,
   output logic             IDEX_WriteEN,
   output logic             IDEX_Flush,
   output logic             Pipe_Freeze,
   output logic             Halted,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);
   import pipe_ctrl_pkg::*;

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   main_state_t        state_reg;
   main_state_t        state_next;
   logic [DRAIN_W-1:0] drain_cnt_reg;
   logic [DRAIN_W-1:0] drain_cnt_next;
   logic               halted_reg;
   logic               halted_next;
   logic [CNT_W-1:0]   stall_cnt_reg;
   logic [CNT_W-1:0]   flush_cnt_reg;

   logic       freeze;
   logic       run_active;
   logic       halt_req;
   logic       hazard;
   logic       branch_flush;
   logic       halt_detect;
   logic       load_use_stall;
   pipe_ctrl_t ctrl;

   logic [4:0] src_addr [2];
   logic [1:0] src_used;
   logic [1:0] src_match;

   mem_wait_ctrl #(
      .MEM_LAT (MEM_LAT)
   ) u_mem_wait (
      .clk        (CLOCK),
      .srst       (RESET),
      .mem_access (MEM_Access),
      .freeze     (freeze)
   );

   // Load-use hazard: a load in EX writes a register the ID instruction
   // reads. Writes to the zero register never create a dependency.
   assign src_addr[0] = ID_RSAddr;
   assign src_addr[1] = ID_RTAddr;
   assign src_used    = {ID_UsesRT, ID_UsesRS};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_match[gi] = src_used[gi] && (src_addr[gi] == EX_DstAddr);
      end
   endgenerate

   assign hazard = ID_Valid && EX_Mem2RegSEL && EX_RegWriteEN &&
                   (EX_DstAddr != REG_ZERO) && (|src_match);

   // Events only count in RUN on cycles the memory wait lets through.
   // A taken branch makes HALT and any hazard in ID wrong-path.
   assign halt_req       = ID_Valid && ID_Halt;
   assign run_active     = (state_reg == MS_RUN) && !freeze;
   assign branch_flush   = run_active && EX_BranchTaken;
   assign halt_detect    = run_active && !EX_BranchTaken && halt_req;
   assign load_use_stall = run_active && !EX_BranchTaken && !halt_req && hazard;

   // State register and counters
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_reg     <= MS_RUN;
         drain_cnt_reg <= '0;
         halted_reg    <= 1'b0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         drain_cnt_reg <= drain_cnt_next;
         halted_reg    <= halted_next;
         if ((freeze || load_use_stall) && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
         if (branch_flush && (flush_cnt_reg != CNT_MAX)) begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
         end
      end
   end

   // Next-state logic: the main FSM only moves on non-frozen cycles, so a
   // memory wait during DRAIN pauses the drain countdown.
   always_comb begin
      state_next     = state_reg;
      drain_cnt_next = drain_cnt_reg;
      halted_next    = halted_reg;
      if (!freeze) begin
         case (state_reg)
            MS_RUN: begin
               if (halt_detect) begin
                  state_next     = MS_DRAIN;
                  drain_cnt_next = DRAIN_LOAD;
               end
            end
            MS_DRAIN: begin
               if (drain_cnt_reg == '0) begin
                  state_next  = MS_HALTED;
                  halted_next = 1'b1;
               end else begin
                  drain_cnt_next = drain_cnt_reg - 1'b1;
               end
            end
            MS_HALTED: state_next = MS_HALTED;
            default:   state_next = MS_RUN;
         endcase
      end
   end

   // Output logic
   always_comb begin
      ctrl = CTRL_NORMAL;
      if (RESET) begin
         ctrl = CTRL_NORMAL;
      end else if (freeze) begin
         ctrl = CTRL_FREEZE;
      end else begin
         case (state_reg)
            MS_RUN: begin
               if (branch_flush) begin
                  ctrl = CTRL_BRANCH;
               end else if (halt_detect) begin
                  ctrl = CTRL_HALT;
               end else if (load_use_stall) begin
                  ctrl = CTRL_STALL;
               end
            end
            MS_DRAIN, MS_HALTED: ctrl = CTRL_DRAIN;
            default:             ctrl = CTRL_NORMAL;
         endcase
      end
   end

   assign PC_WriteEN   = ctrl.pc_we;
   assign IFID_WriteEN = ctrl.ifid_we;
   assign IFID_Flush   = ctrl.ifid_flush;
   assign IDEX_WriteEN = ctrl.idex_we;
   assign IDEX_Flush   = ctrl.idex_flush;
   assign Pipe_Freeze  = ctrl.freeze;
   assign Halted       = halted_reg;
   assign StallCount   = stall_cnt_reg;
   assign FlushCount   = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Three controllers (MEM_LAT 1, 3 and 4; the MEM_LAT=3 one has 4-bit
// counters) see identical stimulus. The driver pushes, per cycle, the
// expected outputs of all three into a queue; the monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int NCFG  = 3;
   localparam int DRAIN = 3;

   function automatic int lat_of(input int idx);
      return (idx == 0) ? 1 : ((idx == 1) ? 3 : 4);
   endfunction

   function automatic int cw_of(input int idx);
      return (idx == 1) ? 4 : 16;
   endfunction

   typedef struct packed {
      logic        pc_we;
      logic        ifid_we;
      logic        ifid_flush;
      logic        idex_we;
      logic        idex_flush;
      logic        freeze;
      logic        halted;
      logic [15:0] stall_cnt;
      logic [15:0] flush_cnt;
   } obs_t;

   typedef obs_t [NCFG-1:0] obs_set_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_halt;
   logic       ex_rw;
   logic       ex_m2r;
   logic [4:0] ex_dst;
   logic       ex_br;
   logic       mem_acc;

   obs_t act [NCFG];

   generate
      for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
         localparam int CW = cw_of(gi);
         logic          pc_we;
         logic          ifid_we;
         logic          ifid_flush;
         logic          idex_we;
         logic          idex_flush;
         logic          pipe_freeze;
         logic          halted;
         logic [CW-1:0] stall_cnt;
         logic [CW-1:0] flush_cnt;

         pipeline_hazard_ctrl #(
            .MEM_LAT      (lat_of(gi)),
            .DRAIN_CYCLES (DRAIN),
            .CNT_W        (CW)
         ) u_dut (
            .CLOCK          (clk),
            .RESET          (rst),
            .ID_Valid       (id_valid),
            .ID_RSAddr      (id_rs),
            .ID_RTAddr      (id_rt),
            .ID_UsesRS      (id_uses_rs),
            .ID_UsesRT      (id_uses_rt),
            .ID_Halt        (id_halt),
            .EX_RegWriteEN  (ex_rw),
            .EX_Mem2RegSEL  (ex_m2r),
            .EX_DstAddr     (ex_dst),
            .EX_BranchTaken (ex_br),
            .MEM_Access     (mem_acc),
            .PC_WriteEN     (pc_we),
            .IFID_WriteEN   (ifid_we),
            .IFID_Flush     (ifid_flush),
            .IDEX_WriteEN   (idex_we),
            .IDEX_Flush     (idex_flush),
            .Pipe_Freeze    (pipe_freeze),
            .Halted         (halted),
            .StallCount     (stall_cnt),
            .FlushCount     (flush_cnt)
         );

         assign act[gi] = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, pipe_freeze,
                           halted, 16'(stall_cnt), 16'(flush_cnt)};
      end
   endgenerate

   // ---------------- reference model ----------------
   // m_busy: cycles left in the current memory access window (the last one
   //         is the release cycle). m_mode: 0 running, 1 draining, 2 halted.
   int m_busy   [NCFG];
   int m_mode   [NCFG];
   int m_drain  [NCFG];
   int m_stall  [NCFG];
   int m_flush  [NCFG];
   bit m_halted [NCFG];

   obs_set_t exp_q [$];
   int       n_checks = 0;
   int       n_fail   = 0;
   int       cyc      = 0;

   task automatic model_step(input int idx, output obs_t e);
      int lat;
      int cmax;
      bit frz;
      bit hz;
      bit halt_req;
      lat  = lat_of(idx);
      cmax = (1 << cw_of(idx)) - 1;
      e            = '0;
      e.pc_we      = 1'b1;
      e.ifid_we    = 1'b1;
      e.idex_we    = 1'b1;
      e.halted     = m_halted[idx];
      e.stall_cnt  = 16'(m_stall[idx]);
      e.flush_cnt  = 16'(m_flush[idx]);
      if (rst) begin
         m_busy[idx]   = 0;
         m_mode[idx]   = 0;
         m_drain[idx]  = 0;
         m_stall[idx]  = 0;
         m_flush[idx]  = 0;
         m_halted[idx] = 1'b0;
         return;
      end
      if (m_busy[idx] > 1) begin
         frz = 1'b1;
         m_busy[idx]--;
      end else if (m_busy[idx] == 1) begin
         frz = 1'b0;
         m_busy[idx] = 0;
      end else begin
         frz = mem_acc && (lat > 1);
         if (frz) m_busy[idx] = lat - 1;
      end
      hz = id_valid && ex_m2r && ex_rw && (ex_dst != 5'd0) &&
           ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));
      halt_req = id_valid && id_halt;
      if (frz) begin
         e.pc_we   = 1'b0;
         e.ifid_we = 1'b0;
         e.idex_we = 1'b0;
         e.freeze  = 1'b1;
         if (m_stall[idx] < cmax) m_stall[idx]++;
      end else if (m_mode[idx] != 0) begin
         e.pc_we      = 1'b0;
         e.ifid_flush = 1'b1;
         e.idex_flush = 1'b1;
         if (m_mode[idx] == 1) begin
            m_drain[idx]--;
            if (m_drain[idx] == 0) begin
               m_mode[idx]   = 2;
               m_halted[idx] = 1'b1;
            end
         end
      end else if (ex_br) begin
         e.ifid_flush = 1'b1;
         e.idex_flush = 1'b1;
         if (m_flush[idx] < cmax) m_flush[idx]++;
      end else if (halt_req) begin
         e.pc_we      = 1'b0;
         e.ifid_flush = 1'b1;
         m_mode[idx]  = 1;
         m_drain[idx] = DRAIN;
      end else if (hz) begin
         e.pc_we      = 1'b0;
         e.ifid_we    = 1'b0;
         e.idex_flush = 1'b1;
         if (m_stall[idx] < cmax) m_stall[idx]++;
      end
   endtask

   // Inputs for this cycle are already applied: record expectations, then
   // move on to the next cycle.
   task automatic tick();
      obs_set_t s;
      obs_t     e;
      for (int i = 0; i < NCFG; i++) begin
         model_step(i, e);
         s[i] = e;
      end
      exp_q.push_back(s);
      @(negedge clk);
   endtask

   task automatic clr();
      rst        = 1'b0;
      id_valid   = 1'b0;
      id_rs      = 5'd0;
      id_rt      = 5'd0;
      id_uses_rs = 1'b0;
      id_uses_rt = 1'b0;
      id_halt    = 1'b0;
      ex_rw      = 1'b0;
      ex_m2r     = 1'b0;
      ex_dst     = 5'd0;
      ex_br      = 1'b0;
      mem_acc    = 1'b0;
   endtask

   task automatic set_hazard(input logic [4:0] r);
      id_valid   = 1'b1;
      id_uses_rs = 1'b1;
      id_rs      = r;
      ex_m2r     = 1'b1;
      ex_rw      = 1'b1;
      ex_dst     = r;
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            obs_set_t s;
            s = exp_q.pop_front();
            for (int i = 0; i < NCFG; i++) begin
               n_checks++;
               if (act[i] !== s[i]) begin
                  n_fail++;
                  $display("FAIL ctrl_lat%0d cyc %0d actual=%h required=%h",
                           lat_of(i), cyc, act[i], s[i]);
               end
            end
            $display("cyc %0d rst=%b v=%b rs=%0d/%b rt=%0d/%b halt=%b ex=%b%b dst=%0d br=%b mem=%b | %h %h %h",
                     cyc, rst, id_valid, id_rs, id_uses_rs, id_rt, id_uses_rt, id_halt,
                     ex_rw, ex_m2r, ex_dst, ex_br, mem_acc, act[0], act[1], act[2]);
            cyc++;
         end
      end
   end

   // ---------------- driver ----------------
   initial begin
      clr();
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // reset state
      tick();
      rst = 1'b0;
      tick();

      // load-use on $5, then the same pattern on $0
      set_hazard(5'd5);
      tick();
      clr();
      tick();
      set_hazard(5'd0);
      tick();
      clr();
      tick();

      // taken branch beats a hazard and a HALT in ID
      set_hazard(5'd5);
      id_halt = 1'b1;
      ex_br   = 1'b1;
      tick();
      clr();
      repeat (2) tick();

      // memory access held high
      mem_acc = 1'b1;
      repeat (6) tick();
      clr();
      repeat (4) tick();

      // HALT, then a memory access during drain
      id_valid = 1'b1;
      id_halt  = 1'b1;
      tick();
      clr();
      tick();
      mem_acc = 1'b1;
      tick();
      mem_acc = 1'b0;
      repeat (8) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // reset in the middle of a memory wait
      mem_acc = 1'b1;
      tick();
      mem_acc = 1'b0;
      rst     = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();

      // back-to-back load-use stalls drive the narrow counter to saturation
      set_hazard(5'd7);
      repeat (20) tick();
      clr();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         rst        = ($urandom_range(0, 59) == 0);
         id_valid   = ($urandom_range(0, 7) != 0);
         id_rs      = 5'($urandom_range(0, 3));
         id_rt      = 5'($urandom_range(0, 3));
         id_uses_rs = ($urandom_range(0, 3) != 0);
         id_uses_rt = ($urandom_range(0, 1) != 0);
         id_halt    = ($urandom_range(0, 39) == 0);
         ex_rw      = ($urandom_range(0, 3) != 0);
         ex_m2r     = ($urandom_range(0, 1) != 0);
         ex_dst     = 5'($urandom_range(0, 3));
         ex_br      = ($urandom_range(0, 7) == 0);
         mem_acc    = ($urandom_range(0, 4) == 0);
         tick();
      end
      clr();

      #5;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/freeze controller for the 5-stage pipeline.
- Drives the write-enables and flushes of PC, IF/ID and ID/EX, plus a global freeze for EX/MEM and MEM/WB.
- Handles load-use stalls, taken-branch flushes (branches resolve in EX), multi-cycle data-memory waits, and HALT drain.
- Keeps saturating stall and flush performance counters.

Parameters:
- MEM_LAT, 1, data-memory access latency in cycles (1 = no wait).
- DRAIN_CYCLES, 3, non-frozen cycles after HALT leaves ID before Halted asserts.
- CNT_W, 16, width of the performance counters.

Ports:
- CLOCK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- ID_Valid  in  1  IF/ID holds a real instruction.
- ID_RSAddr  in  5  rs field of the instruction in ID.
- ID_RTAddr  in  5  rt field of the instruction in ID.
- ID_UsesRS  in  1  ID instruction reads rs.
- ID_UsesRT  in  1  ID instruction reads rt.
- ID_Halt  in  1  ID instruction is HALT.
- EX_RegWriteEN  in  1  RegWriteEN out of ID/EX.
- EX_Mem2RegSEL  in  1  Mem2RegSEL out of ID/EX (load in EX).
- EX_DstAddr  in  5  resolved destination register of the EX instruction.
- EX_BranchTaken  in  1  branch in EX is taken.
- MEM_Access  in  1  instruction in MEM is a load or store.
- PC_WriteEN  out  1  PC update enable.
- IFID_WriteEN  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID loads a bubble.
- IDEX_WriteEN  out  1  ID/EX load enable.
- IDEX_Flush  out  1  ID/EX loads a bubble (all control bits 0).
- Pipe_Freeze  out  1  EX/MEM and MEM/WB hold their contents.
- Halted  out  1  sticky halt indication.
- StallCount  out  CNT_W  load-use stall cycles plus freeze cycles.
- FlushCount  out  CNT_W  taken-branch flush events.

Behaviour:
- Control outputs are combinational from registered state and current inputs.
- Counters, Halted and both FSMs are registered.

Reset:
- Both FSMs go to their idle/run state. WaitCnt, DrainCnt, StallCount, FlushCount and Halted are cleared.
- While RESET is high: PC_WriteEN=1, IFID_WriteEN=1, IDEX_WriteEN=1, all flushes=0, Pipe_Freeze=0.

Memory-wait sub-FSM, states MW_IDLE and MW_WAIT:
- MW_IDLE with MEM_Access=1 and MEM_LAT>1: freeze this cycle, WaitCnt<=MEM_LAT-2, go to MW_WAIT.
- MW_WAIT with WaitCnt!=0: freeze, decrement WaitCnt.
- MW_WAIT with WaitCnt==0: no freeze, go to MW_IDLE. MEM_Access is ignored this cycle, because it is the same instruction.
- Total freeze per access = MEM_LAT-1 cycles.
- Freeze forces PC_WriteEN=0, IFID_WriteEN=0, IDEX_WriteEN=0, Pipe_Freeze=1, all flushes=0.

Main FSM, states RUN, DRAIN and HALTED; it advances only on non-frozen cycles. Priority: freeze > branch flush > halt detect > load-use stall.

RUN:
- Branch flush: EX_BranchTaken=1 gives IFID_Flush=1, IDEX_Flush=1 and FlushCount+1; PC loads the target. A HALT or load-use hazard in ID the same cycle is wrong-path and is ignored.
- Halt detect: ID_Valid and ID_Halt with no taken branch gives PC_WriteEN=0 and IFID_Flush=1; HALT proceeds into ID/EX; DrainCnt<=DRAIN_CYCLES-1; go to DRAIN.
- Load-use stall when all of these hold:
  - ID_Valid, EX_Mem2RegSEL and EX_RegWriteEN are 1;
  - EX_DstAddr!=0;
  - (ID_UsesRS and ID_RSAddr==EX_DstAddr) or (ID_UsesRT and ID_RTAddr==EX_DstAddr).
  - Response: PC_WriteEN=0, IFID_WriteEN=0, IDEX_Flush=1, StallCount+1, for exactly one cycle.
- Otherwise every enable is 1 and every flush is 0.

DRAIN:
- PC_WriteEN=0, IFID_Flush=1, IDEX_Flush=1.
- DrainCnt decrements each non-frozen cycle; at 0 set Halted=1 and go to HALTED.
- A freeze during DRAIN pauses DrainCnt.

HALTED:
- Same outputs as DRAIN; leaves only on RESET.

Counters:
- StallCount also increments on every freeze cycle.
- Both counters saturate at 2^CNT_W-1.

Reset mid-wait or mid-drain: the state is abandoned with no residual freeze; the next cycle is normal RUN.

Decomposition:
- Package pipe_ctrl_pkg holds the main-FSM encoding (RUN/DRAIN/HALTED), the MW-FSM encoding, and the REG_ZERO=5'd0 constant.
- One natural sub-module, mem_wait_ctrl: the memory-wait sub-FSM plus WaitCnt, outputting Freeze.

Test Plan:
- Load-use: EX load to $5 (EX_Mem2RegSEL=1, EX_DstAddr=5), ID uses rs=5 -> one cycle with PC_WriteEN=0, IFID_WriteEN=0, IDEX_Flush=1; StallCount=1; next cycle all enables 1. Repeat with EX_DstAddr=0 -> no stall.
- Branch vs hazard: EX_BranchTaken=1 while ID has a load-use hazard on $5 and ID_Halt=1 -> IFID_Flush=1, IDEX_Flush=1, no stall, no DRAIN, FlushCount=1.
- Memory wait, MEM_LAT=4, MEM_Access held high -> Pipe_Freeze=1 for exactly 3 cycles, released on the 4th, no retrigger; StallCount=3. MEM_LAT=1 -> never freezes.
- Halt: HALT in ID, no branch -> DRAIN; Halted rises after 3 non-frozen cycles. Inject a MEM_LAT=3 access during DRAIN -> Halted delayed by 2 cycles. PC_WriteEN stays 0 afterwards.
- Reset mid-wait: RESET asserted in MW_WAIT with WaitCnt=2 -> next cycle Pipe_Freeze=0, all enables 1, counters 0, Halted 0.
- Saturation, CNT_W=4: 20 back-to-back load-use stalls -> StallCount holds at 15.
